io_bus_responder: RTL and testbench

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_bus_responder_pkg.sv | 17 +
 rtl/io_bus_responder_if.sv | 18 +
 rtl/io_bus_responder_fifo.sv | 80 ++++++++
 rtl/io_bus_responder.sv | 140 ++++++++++++++
 tb/tb_io_bus_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_responder_pkg.sv
// io_bus_responder_pkg
//   Shared constants for the IO bus responder: the peripheral address map
//   and the default parameter values used by the top and its FIFO.
package io_bus_responder_pkg;

    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_IN_STAT  = 8'h04;
    localparam logic [7:0] ADDR_IN_DATA  = 8'h08;
    localparam logic [7:0] ADDR_OUT_STAT = 8'h0C;
    localparam logic [7:0] ADDR_OUT_DATA = 8'h10;
    localparam logic [7:0] ADDR_SW       = 8'h14;
    localparam logic [7:0] ADDR_DROP     = 8'h18;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int SW_W_DEF       = 16;

endpackage

// File: rtl/io_bus_responder_if.sv
// io_bus_responder_if
//   CPU-side peripheral bus.
//   io_addr  : byte address from the CPU
//   io_dout  : write data from the CPU
//   io_we    : one-cycle write strobe
//   io_rd    : one-cycle read strobe
//   io_din   : read data back to the CPU (combinational from io_addr)
//   Modports: master = CPU side, slave = responder side.
interface io_bus_responder_if;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (output io_addr, output io_dout, output io_we, output io_rd, input io_din);
    modport slave  (input io_addr, input io_dout, input io_we, input io_rd, output io_din);
endinterface

// File: rtl/io_bus_responder_fifo.sv
// io_fifo
//   Synchronous FIFO used as the responder's output queue.
//   clk, rst   : clock, synchronous active-high reset (clears pointers/count)
//   push       : push request; accepted when not full, or when full and a
//                pop happens on the same edge
//   push_data  : word to push
//   pop        : pop request; ignored when empty
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
//   head       : oldest entry (valid while !empty)
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // A full queue can still take a word when the head leaves this edge.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count/pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder
//   Memory-mapped peripheral: LED register, switch readback, a single-word
//   input latch with ready/overrun status, and an output FIFO with a
//   saturating drop counter.
//   clk, rst  : clock, synchronous active-high reset
//   io        : CPU bus (slave modport)
//   led       : LED register output
//   sw        : synchronised switch levels
//   in_valid  : one-cycle pulse, in_data is a new word
//   in_data   : input word
//   out_valid : output FIFO head valid
//   out_data  : output FIFO head word
//   out_ready : consumer takes the head when out_valid && out_ready
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SW_W       = SW_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    io_bus_responder_if.slave    io,
    output logic [SW_W-1:0]      led,
    input  logic [SW_W-1:0]      sw,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [SW_W-1:0]  led_q, led_d;
    logic             in_rdy_q, in_rdy_d;
    logic             overrun_q, overrun_d;
    logic [31:0]      in_data_q, in_data_d;
    logic [31:0]      drop_q, drop_d;

    logic             wr_led;
    logic             wr_out;
    logic             rd_in_stat;
    logic             rd_in_data;
    logic             pop_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      rd_data;

    assign wr_led     = io.io_we && (io.io_addr == ADDR_LED);
    assign wr_out     = io.io_we && (io.io_addr == ADDR_OUT_DATA);
    assign rd_in_stat = io.io_rd && (io.io_addr == ADDR_IN_STAT);
    assign rd_in_data = io.io_rd && (io.io_addr == ADDR_IN_DATA);

    assign out_valid = !fifo_empty;
    assign pop_fire  = out_valid && out_ready;
    assign led       = led_q;

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_out),
        .push_data (io.io_dout),
        .pop       (pop_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (out_data)
    );

    always_comb begin
        rd_data = '0;
        case (io.io_addr)
            ADDR_LED:      rd_data = 32'(led_q);
            ADDR_IN_STAT:  rd_data = {30'b0, overrun_q, in_rdy_q};
            ADDR_IN_DATA:  rd_data = in_data_q;
            ADDR_OUT_STAT: rd_data = ((32'(fifo_count) << 4) & 32'h0000_00F0)
                                     | {31'b0, !fifo_full};
            ADDR_SW:       rd_data = 32'(sw);
            ADDR_DROP:     rd_data = drop_q;
            default:       rd_data = '0;
        endcase
    end

    assign io.io_din = rd_data;

    always_comb begin
        led_d     = led_q;
        in_rdy_d  = in_rdy_q;
        overrun_d = overrun_q;
        in_data_d = in_data_q;
        drop_d    = drop_q;

        if (wr_led) begin
            led_d = io.io_dout[SW_W-1:0];
        end

        // A new word arriving in the same cycle as the pop keeps the latch
        // full, so the ordering of these two assignments matters.
        if (rd_in_data) begin
            in_rdy_d = 1'b0;
        end
        if (in_valid) begin
            in_data_d = in_data;
            in_rdy_d  = 1'b1;
        end

        // Overrun set beats the clear-on-read of the status register.
        if (rd_in_stat) begin
            overrun_d = 1'b0;
        end
        if (in_valid && in_rdy_q && !rd_in_data) begin
            overrun_d = 1'b1;
        end

        if (wr_out && fifo_full && !pop_fire && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            in_rdy_q  <= 1'b0;
            overrun_q <= 1'b0;
            in_data_q <= '0;
            drop_q    <= '0;
        end else begin
            led_q     <= led_d;
            in_rdy_q  <= in_rdy_d;
            overrun_q <= overrun_d;
            in_data_q <= in_data_d;
            drop_q    <= drop_d;
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder
//   Directed, self-checking bench for io_bus_responder. Inputs change 1 ns
//   after a rising edge; outputs are checked before the next rising edge.
module tb_io_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led;
    logic [15:0] sw;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    io_bus_responder_if bus ();

    io_bus_responder #(
        .FIFO_DEPTH (4),
        .SW_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (bus.slave),
        .led       (led),
        .sw        (sw),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [31:0] data);
        bus.io_addr = addr;
        bus.io_dout = data;
        bus.io_we   = 1'b1;
        tick();
        bus.io_we   = 1'b0;
    endtask

    // Read with side effects: checks io_din before the edge that commits the read.
    task automatic io_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        bus.io_addr = addr;
        bus.io_rd   = 1'b1;
        #1;
        chk(bus.io_din, exp, tag);
        tick();
        bus.io_rd   = 1'b0;
    endtask

    // Look at io_din without a read strobe (no side effects).
    task automatic peek(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        bus.io_addr = addr;
        #1;
        chk(bus.io_din, exp, tag);
    endtask

    task automatic pulse_in(input logic [31:0] data);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        sw          = 16'h3C5A;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        bus.io_addr = 8'h00;
        bus.io_dout = '0;
        bus.io_we   = 1'b0;
        bus.io_rd   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk(32'(led), 32'h0, "reset_led");
        chk(32'(out_valid), 32'h0, "reset_out_valid");
        peek(8'h04, 32'h0, "reset_in_stat");
        peek(8'h0C, 32'h1, "reset_out_stat");
        peek(8'h18, 32'h0, "reset_drop");

        // LED register
        io_write(8'h00, 32'h0000A5A5);
        chk(32'(led), 32'h0000A5A5, "led_write");
        io_read(8'h00, 32'h0000A5A5, "led_readback");

        // Switches, unmapped and read-only addresses
        peek(8'h14, 32'h00003C5A, "sw_read");
        peek(8'h1C, 32'h0, "unmapped_read");
        io_write(8'h14, 32'hFFFFFFFF);
        peek(8'h14, 32'h00003C5A, "sw_write_ignored");
        io_write(8'h1C, 32'hFFFFFFFF);
        chk(32'(led), 32'h0000A5A5, "unmapped_write_led");

        // Single input word
        pulse_in(32'h12345678);
        io_read(8'h04, 32'h1, "in_stat_ready");
        io_read(8'h08, 32'h12345678, "in_data_pop");
        peek(8'h04, 32'h0, "in_stat_after_pop");

        // Two words without a read: overrun, last word kept
        pulse_in(32'h1);
        pulse_in(32'h2);
        io_read(8'h04, 32'h3, "overrun_set");
        peek(8'h08, 32'h2, "overrun_data");
        io_read(8'h04, 32'h1, "overrun_cleared");
        io_read(8'h08, 32'h2, "overrun_pop");
        peek(8'h04, 32'h0, "stat_empty_again");

        // Pop and new word on the same edge: stays ready, no overrun
        pulse_in(32'h55);
        in_valid    = 1'b1;
        in_data     = 32'h66;
        bus.io_addr = 8'h08;
        bus.io_rd   = 1'b1;
        #1;
        chk(bus.io_din, 32'h55, "pop_and_new_old_word");
        tick();
        in_valid  = 1'b0;
        bus.io_rd = 1'b0;
        peek(8'h04, 32'h1, "pop_and_new_stat");
        peek(8'h08, 32'h66, "pop_and_new_data");

        // Status read and overrun on the same edge: overrun wins
        in_valid    = 1'b1;
        in_data     = 32'h77;
        bus.io_addr = 8'h04;
        bus.io_rd   = 1'b1;
        #1;
        chk(bus.io_din, 32'h1, "stat_read_vs_overrun_pre");
        tick();
        in_valid  = 1'b0;
        bus.io_rd = 1'b0;
        peek(8'h04, 32'h3, "overrun_wins");
        io_read(8'h04, 32'h3, "overrun_wins_read");
        peek(8'h04, 32'h1, "overrun_cleared2");

        // Output FIFO: five pushes into a depth-4 queue, consumer stalled
        io_write(8'h10, 32'h10);
        chk(32'(out_valid), 32'h1, "push_latency_valid");
        chk(out_data, 32'h10, "push_latency_data");
        for (int i = 1; i < 5; i++) io_write(8'h10, 32'h10 + 32'(i));
        peek(8'h0C, 32'h40, "fifo_full_stat");
        peek(8'h18, 32'h1, "drop_count_one");
        tick();
        chk(out_data, 32'h10, "head_stable_stalled");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk(out_data, 32'h10 + 32'(i), "drain_order");
            tick();
        end
        out_ready = 1'b0;
        chk(32'(out_valid), 32'h0, "drained_empty");

        // Push into a full queue while the head leaves
        for (int i = 0; i < 4; i++) io_write(8'h10, 32'h20 + 32'(i));
        peek(8'h0C, 32'h40, "refill_full");
        out_ready   = 1'b1;
        bus.io_addr = 8'h10;
        bus.io_dout = 32'hAA;
        bus.io_we   = 1'b1;
        #1;
        chk(out_data, 32'h20, "full_push_pop_head");
        tick();
        bus.io_we = 1'b0;
        out_ready = 1'b0;
        peek(8'h0C, 32'h40, "full_push_pop_count");
        peek(8'h18, 32'h1, "full_push_pop_drop");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk(out_data, (i == 3) ? 32'hAA : 32'h21 + 32'(i), "drain_with_aa");
            tick();
        end
        out_ready = 1'b0;
        peek(8'h0C, 32'h1, "empty_after_aa");

        // Reset mid-operation with a simultaneous push
        io_write(8'h00, 32'h1234);
        for (int i = 0; i < 3; i++) io_write(8'h10, 32'h31 + 32'(i));
        peek(8'h0C, 32'h31, "three_words_stat");
        rst         = 1'b1;
        bus.io_addr = 8'h10;
        bus.io_dout = 32'h99;
        bus.io_we   = 1'b1;
        tick();
        rst       = 1'b0;
        bus.io_we = 1'b0;
        chk(32'(out_valid), 32'h0, "rst_out_valid");
        chk(32'(led), 32'h0, "rst_led");
        peek(8'h0C, 32'h1, "rst_count");
        peek(8'h18, 32'h0, "rst_drop");
        peek(8'h04, 32'h0, "rst_in_stat");
        io_write(8'h10, 32'h44);
        chk(out_data, 32'h44, "post_rst_head");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
